icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 113 +++++++++++
 tb/tb_icache.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 16 one-word frames with zero-cycle hit and one-word refill.
// Optional hit/miss counters are built only when ICACHE_STATS_EN is defined.
module icache (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam logic IDLE  = 1'b0;
  localparam logic FETCH = 1'b1;

  logic        state_q, state_d;
  logic [31:0] miss_addr_q, miss_addr_d;
  logic [15:0] valid_q, valid_d;
  logic [25:0] tag_q  [16];
  logic [31:0] data_q [16];

  logic [3:0]  req_idx;
  logic [25:0] req_tag;
  logic [3:0]  fill_idx;
  logic        hit_w;
  logic        fill_we;
  logic        miss_w;

  assign req_idx  = imemaddr[5:2];
  assign req_tag  = imemaddr[31:6];
  assign fill_idx = miss_addr_q[5:2];

  // Reset gates every output so nothing leaks while RST is held.
  assign hit_w   = !RST && (state_q == IDLE) && imemREN &&
                   valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss_w  = !RST && (state_q == IDLE) && imemREN && !hit_w;
  assign fill_we = !RST && (state_q == FETCH) && !iwait;

  assign ihit     = hit_w;
  assign imemload = hit_w ? data_q[req_idx] : 32'h0;
  assign iREN     = !RST && (state_q == FETCH);
  assign iaddr    = iREN ? miss_addr_q : 32'h0;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE: begin
        if (miss_w) begin
          state_d     = FETCH;
          miss_addr_d = imemaddr;
        end
      end
      FETCH: begin
        // A redirect on imemaddr is ignored here; the latched fill always completes.
        if (!iwait) begin
          state_d           = IDLE;
          valid_d[fill_idx] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= 32'h0;
      valid_q     <= 16'h0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data need no reset: the valid bits qualify every hit.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= miss_addr_q[31:6];
      data_q[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      if (hit_w && (hit_cnt_q != 32'hFFFF_FFFF))
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_w && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache: a word-address reference model predicts each cycle's outputs.
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b0;
  logic [31:0] iload = 32'h0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 CLK = ~CLK;

  icache dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct {
    logic        ihit;
    logic [31:0] load;
    logic        iren;
    logic [31:0] iaddr;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: each index holds the word address it caches.
  logic [31:0] line_addr [int];
  logic [31:0] line_data [int];
  logic [31:0] mem_img   [logic [31:0]];
  bit          fetching = 0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] m_hits = 32'h0;
  logic [31:0] m_misses = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int idx = int'((a >> 2) % 16);
    return line_addr.exists(idx) && ((line_addr[idx] >> 6) == (a >> 6));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit ren, input logic [31:0] addr, input bit wt);
    exp_t e;
    bit   h;
    @(posedge CLK);
    #1;
    RST      = rst;
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = fetching ? mem_word(paddr) : $urandom;
    h = !rst && !fetching && ren && model_hit(addr);
    e.ihit  = h;
    e.load  = h ? line_data[int'((addr >> 2) % 16)] : 32'h0;
    e.iren  = !rst && fetching;
    e.iaddr = (!rst && fetching) ? paddr : 32'h0;
    e.hc    = m_hits;
    e.mc    = m_misses;
    exp_q.push_back(e);
    @(negedge CLK);
    if (rst) begin
      line_addr.delete();
      line_data.delete();
      fetching = 0;
      paddr    = 32'h0;
      m_hits   = 32'h0;
      m_misses = 32'h0;
    end else if (fetching) begin
      if (!wt) begin
        line_addr[int'((paddr >> 2) % 16)] = paddr;
        line_data[int'((paddr >> 2) % 16)] = mem_word(paddr);
        fetching = 0;
      end
    end else if (ren) begin
      if (h) begin
        if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
      end else begin
        fetching = 1;
        paddr    = addr;
        if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
      end
    end
  endtask

  // Monitor: compares every cycle for which an expectation was queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ihit", {31'h0, ihit}, {31'h0, e.ihit});
        chk("imemload", imemload, e.load);
        chk("iREN", {31'h0, iREN}, {31'h0, e.iren});
        chk("iaddr", iaddr, e.iaddr);
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, e.hc);
        chk("miss_count", miss_count, e.mc);
`endif
      end
    end
  end

  initial begin
    mem_img[32'h0000_0040] = 32'h8C22_0004;
    mem_img[32'h0000_0080] = 32'h2108_0001;

    // Cold miss with three wait cycles, then hits.
    cycle(1, 0, 32'h0, 0);
    cycle(1, 0, 32'h0, 0);
    cycle(0, 1, 32'h40, 1);
    repeat (3) cycle(0, 1, 32'h40, 1);
    cycle(0, 1, 32'h40, 0);
    repeat (3) cycle(0, 1, 32'h40, 0);

    // Conflict on index 0 evicts and refills.
    cycle(0, 1, 32'h80, 0);
    cycle(0, 1, 32'h80, 0);
    cycle(0, 1, 32'h80, 0);
    cycle(0, 1, 32'h40, 0);
    cycle(0, 1, 32'h40, 0);
    cycle(0, 1, 32'h40, 0);
`ifdef ICACHE_STATS_EN
    chk("miss_count_after_conflict", m_misses, 32'd3);
`endif

    // Redirect during a fill.
    cycle(0, 1, 32'h100, 0);
    cycle(0, 1, 32'h200, 1);
    cycle(0, 0, 32'h200, 0);
    cycle(0, 1, 32'h200, 0);
    cycle(0, 1, 32'h200, 0);
    cycle(0, 1, 32'h100, 0);
    cycle(0, 1, 32'h200, 0);

    // Reset while the fill would complete; the frame must stay invalid.
    cycle(1, 0, 32'h0, 0);
    cycle(0, 1, 32'h100, 0);
    cycle(1, 1, 32'h100, 0);
    cycle(0, 1, 32'h100, 0);
    cycle(0, 1, 32'h100, 0);
    cycle(0, 1, 32'h100, 0);

    // Read disabled on a valid, matching frame.
    cycle(0, 0, 32'h100, 0);
    cycle(0, 0, 32'h100, 1);

    // Random traffic over a small address pool so hits and conflicts are frequent.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 8,
            32'($urandom_range(0, 63)) << 2,
            $urandom_range(0, 9) < 3);
    end

    repeat (2) @(negedge CLK);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
